// File: rtl/cpu_sequencer.sv
// Control sequencer for a small 16-bit register-file CPU.
// Instructions are fetched through a req/ack memory port, then decoded and executed as register-file and memory strobes.
module cpu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [2:0]  src_sel,
    output logic [2:0]  dst_sel,
    output logic        in_en,
    output logic [1:0]  in_sel,
    output logic [15:0] imm,
    output logic        pc_inc,
    output logic [15:0] ir,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MOV   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] SEL_SRC = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_IMM = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [3:0]  w_opcode;
    logic [2:0]  w_dst;
    logic [2:0]  w_src;

    assign w_opcode = r_ir[15:12];
    assign w_dst    = r_ir[11:9];
    assign w_src    = r_ir[8:6];

    assign ir  = r_ir;
    assign imm = {10'd0, r_ir[5:0]};

    // NOTE: sequential state uses non-blocking assignments; all strobes are decoded
    // combinationally from r_state, so the async reset clears them in the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= 16'd0;
        end else if (r_state == S_FETCH && mem_ack) begin
            r_ir <= mem_rdata;
        end
    end

    // NOTE: every output and w_next gets a default first so no latch is inferred.
    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        src_sel  = 3'd0;
        dst_sel  = 3'd0;
        in_en    = 1'b0;
        in_sel   = SEL_SRC;
        pc_inc   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_inc = 1'b1;
                    w_next = S_DECODE;
                end
            end

            S_DECODE: begin
                w_next = S_EXEC;
            end

            S_EXEC: begin
                src_sel = w_src;
                dst_sel = w_dst;
                w_next  = S_FETCH;
                case (w_opcode)
                    OP_NOP: ;
                    OP_MOV: begin
                        in_en  = 1'b1;
                        in_sel = SEL_SRC;
                    end
                    OP_ADD: begin
                        in_en  = 1'b1;
                        in_sel = SEL_ALU;
                    end
                    OP_LDI: begin
                        in_en  = 1'b1;
                        in_sel = SEL_IMM;
                    end
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_HALT:           w_next = S_HALT;
                    default:           illegal = 1'b1;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                src_sel  = w_src;
                dst_sel  = w_dst;
                mem_we   = (w_opcode == OP_STORE);
                if (mem_ack) begin
                    if (w_opcode == OP_LOAD) begin
                        in_en  = 1'b1;
                        in_sel = SEL_MEM;
                    end
                    w_next = S_FETCH;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic [2:0]  src_sel;
    logic [2:0]  dst_sel;
    logic        in_en;
    logic [1:0]  in_sel;
    logic [15:0] imm;
    logic        pc_inc;
    logic [15:0] ir;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    int en_cnt;
    int ill_cnt;

    cpu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .in_en     (in_en),
        .in_sel    (in_sel),
        .imm       (imm),
        .pc_inc    (pc_inc),
        .ir        (ir),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive memory inputs on the falling edge, settle, then the caller checks.
    task automatic cyc(input logic ack, input logic [15:0] rd);
        @(negedge clk);
        mem_ack   = ack;
        mem_rdata = rd;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'd0;

        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_ir",      ir, 0);
        check("rst_halted",  halted, 0);
        check("rst_pc_inc",  pc_inc, 0);
        check("rst_in_en",   in_en, 0);

        cyc(0, 0);
        cyc(0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0);
            check("idle_no_req", mem_req, 0);
        end

        // LDI r5,5 with zero-wait fetch
        @(negedge clk);
        run = 1'b1;
        cyc(1, 16'h5A05);
        run = 1'b0;
        check("ldi_fetch_req",  mem_req, 1);
        check("ldi_fetch_asel", addr_sel, 0);
        check("ldi_fetch_ssel", src_sel, 0);
        check("ldi_fetch_we",   mem_we, 0);
        check("ldi_fetch_pc",   pc_inc, 1);
        cyc(0, 0);
        check("ldi_dec_ir",     ir, 32'h5A05);
        check("ldi_dec_pc",     pc_inc, 0);
        check("ldi_dec_en",     in_en, 0);
        check("ldi_dec_req",    mem_req, 0);
        cyc(0, 0);
        check("ldi_exec_en",    in_en, 1);
        check("ldi_exec_dst",   dst_sel, 5);
        check("ldi_exec_isel",  in_sel, 3);
        check("ldi_exec_imm",   imm, 32'h0005);
        check("ldi_exec_pc",    pc_inc, 0);

        // Fetch with 4 wait cycles, then LOAD r3 <= mem[r2]
        for (int i = 0; i < 4; i++) begin
            cyc(0, 16'hDEAD);
            check("wait_req",  mem_req, 1);
            check("wait_asel", addr_sel, 0);
            check("wait_pc",   pc_inc, 0);
        end
        cyc(1, 16'h3680);
        check("load_fetch_pc", pc_inc, 1);
        cyc(0, 0);
        check("load_dec_ir",   ir, 32'h3680);
        cyc(0, 0);
        check("load_exec_req", mem_req, 0);
        check("load_exec_en",  in_en, 0);
        cyc(0, 0);
        check("load_mem_req",  mem_req, 1);
        check("load_mem_asel", addr_sel, 1);
        check("load_mem_ssel", src_sel, 2);
        check("load_mem_we",   mem_we, 0);
        check("load_mem_en",   in_en, 0);
        cyc(1, 16'hBEEF);
        check("load_ack_en",   in_en, 1);
        check("load_ack_isel", in_sel, 2);
        check("load_ack_dst",  dst_sel, 3);
        check("load_ack_pc",   pc_inc, 0);

        // STORE: mem_we in MEM, no register write anywhere in the instruction
        en_cnt = 0;
        cyc(1, 16'h4280);
        check("store_fetch_pc", pc_inc, 1);
        en_cnt += int'(in_en);
        cyc(0, 0);
        en_cnt += int'(in_en);
        cyc(0, 0);
        en_cnt += int'(in_en);
        cyc(1, 0);
        check("store_mem_we",   mem_we, 1);
        check("store_mem_req",  mem_req, 1);
        check("store_mem_asel", addr_sel, 1);
        en_cnt += int'(in_en);
        check("store_no_in_en", en_cnt, 0);

        // Undefined opcode 0x7: one-cycle illegal pulse, then FETCH
        ill_cnt = 0;
        cyc(1, 16'h7000);
        ill_cnt += int'(illegal);
        cyc(0, 0);
        ill_cnt += int'(illegal);
        cyc(0, 0);
        check("ill_exec_flag", illegal, 1);
        ill_cnt += int'(illegal);
        cyc(1, 16'hF000);
        check("ill_next_fetch", mem_req, 1);
        check("ill_fetch_pc",   pc_inc, 1);
        ill_cnt += int'(illegal);
        check("ill_pulse_count", ill_cnt, 1);

        // HALT persists despite run and mem_ack activity
        cyc(0, 0);
        cyc(0, 0);
        check("halt_exec_not_yet", halted, 0);
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            cyc(i[1], 16'h1111);
            check("halt_hold",   halted, 1);
            check("halt_no_req", mem_req, 0);
            check("halt_no_pc",  pc_inc, 0);
        end

        // Reset during a MEM wait
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_leaves_halt", halted, 0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        cyc(1, 16'h3680);
        run = 1'b0;
        check("rst2_fetch_pc", pc_inc, 1);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        check("rst2_mem_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_req_drop", mem_req, 0);
        check("async_no_en",    in_en, 0);
        check("async_no_pc",    pc_inc, 0);
        cyc(1, 16'hBEEF);
        check("rst_held_no_en", in_en, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'hBEEF);
            check("post_rst_idle_req", mem_req, 0);
            check("post_rst_idle_pc",  pc_inc, 0);
            check("post_rst_idle_en",  in_en, 0);
        end
        @(negedge clk);
        run = 1'b1;
        cyc(0, 0);
        check("post_rst_run_fetch", mem_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
